ifu_fetch: RTL and testbench

Instruction fetch unit that sits directly upstream of the IF/ID pipeline register. It owns the PC and issues word fetches on a req/gnt/rvalid instruction bus. Returned words are buffered in a small in-order queue, and the unit presents one {inst, inst_addr} pair per cycle to the IF/ID register. It handles pipeline holds and jump flushes, including discarding in-flight responses.

---
 rtl/define.v | 15 +
 rtl/fetch_queue.sv | 65 ++++++
 rtl/ifu_fetch.sv | 91 +++++++++
 tb/tb_ifu_fetch.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/define.v
// Shared core-wide macros: instruction encodings, hold codes and bus widths.
`ifndef IFU_DEFINE_V
`define IFU_DEFINE_V

`define INST_NOP      32'h0000_0013
`define Hold_Flag_Bus 2:0
`define Hold_None     3'b000
`define Hold_Pc       3'b001
`define Hold_If       3'b010
`define Hold_Id       3'b011
`define InstBus       31:0
`define InstAddrBus   31:0
`define IbusAddrBus   31:0

`endif

// File: rtl/fetch_queue.sv
// In-order fetch queue: entries are allocated when a request is granted and
// filled when its response returns; the head is popped once its data is valid.
module fetch_queue #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        clear,
  input  logic        alloc,
  input  logic [31:0] alloc_addr,
  input  logic        fill,
  input  logic [31:0] fill_data,
  input  logic        pop,
  output logic        head_ready,
  output logic [31:0] head_addr,
  output logic [31:0] head_data,
  output logic        full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0]            head;
  logic [PW-1:0]            tail;
  logic [PW-1:0]            fptr;   // oldest allocated entry still waiting for data
  logic [CW-1:0]            count;
  logic [DEPTH-1:0][31:0]   addr_q;
  logic [DEPTH-1:0][31:0]   data_q;
  logic [DEPTH-1:0]         dvalid_q;

  assign head_ready = (count != '0) && dvalid_q[head];
  assign head_addr  = addr_q[head];
  assign head_data  = data_q[head];
  assign full       = (count == CW'(DEPTH));

  // Pointers, occupancy and per-entry data-valid flags; DEPTH is a power of
  // two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rstn || clear) begin
      head     <= '0;
      tail     <= '0;
      fptr     <= '0;
      count    <= '0;
      dvalid_q <= '0;
    end else begin
      if (alloc) begin
        dvalid_q[tail] <= 1'b0;
        tail           <= tail + 1'b1;
      end
      // fptr never equals tail while a fill is legal, so the two writes to
      // dvalid_q always hit different entries.
      if (fill) begin
        dvalid_q[fptr] <= 1'b1;
        fptr           <= fptr + 1'b1;
      end
      if (pop) head <= head + 1'b1;
      count <= count + CW'(alloc) - CW'(pop);
    end
  end

  // Payload storage needs no reset; dvalid_q/count qualify it.
  always_ff @(posedge clk) begin
    if (alloc) addr_q[tail] <= alloc_addr;
    if (fill)  data_q[fptr] <= fill_data;
  end
endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues word fetches on a req/gnt/rvalid
// bus, buffers responses in order and presents one {inst, addr} per cycle.
`include "define.v"

module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  jump_flag_i,
  input  logic [31:0]           jump_addr_i,
  input  logic [`Hold_Flag_Bus] hold_flag_i,
  output logic                  ibus_req_o,
  output logic [`IbusAddrBus]   ibus_addr_o,
  input  logic                  ibus_gnt_i,
  input  logic                  ibus_rvalid_i,
  input  logic [31:0]           ibus_rdata_i,
  output logic [`InstBus]       inst_o,
  output logic [`InstAddrBus]   inst_addr_o
);
  localparam int CW = $clog2(DEPTH + 1);
  // Back-to-back jumps can stack discards beyond DEPTH, so leave headroom.
  localparam int DW = CW + 2;

  logic [31:0]   pc;
  logic [CW-1:0] outstanding;
  logic [DW-1:0] discard;
  logic          hold_en;
  logic          pop;
  logic          grant;
  logic          drop;
  logic          fill;
  logic          head_ready;
  logic          full;
  logic [31:0]   head_addr;
  logic [31:0]   head_data;

  assign hold_en = (hold_flag_i >= `Hold_If);
  assign pop     = rstn && !hold_en && !jump_flag_i && head_ready;
  // A slot freed by this cycle's pop is reusable at once; this keeps a
  // 2-entry queue streaming at one instruction per cycle.
  assign ibus_req_o  = rstn && !jump_flag_i && (!full || pop);
  assign ibus_addr_o = pc;
  assign grant       = ibus_req_o && ibus_gnt_i;
  assign drop        = ibus_rvalid_i && (discard != '0);
  // The response landing in a jump cycle belongs to the flushed stream.
  assign fill        = ibus_rvalid_i && (discard == '0) && !jump_flag_i;

  assign inst_o      = (rstn && head_ready) ? head_data : `INST_NOP;
  assign inst_addr_o = (rstn && head_ready) ? head_addr : 32'h0;

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk        (clk),
    .rstn       (rstn),
    .clear      (jump_flag_i),
    .alloc      (grant),
    .alloc_addr (pc),
    .fill       (fill),
    .fill_data  (ibus_rdata_i),
    .pop        (pop),
    .head_ready (head_ready),
    .head_addr  (head_addr),
    .head_data  (head_data),
    .full       (full)
  );

  // PC: redirect on jump, otherwise advance one word per granted fetch.
  always_ff @(posedge clk) begin
    if (!rstn)            pc <= RESET_PC;
    else if (jump_flag_i) pc <= {jump_addr_i[31:2], 2'b00};
    else if (grant)       pc <= pc + 32'd4;
  end

  // Outstanding fetches whose data will land in the queue.
  always_ff @(posedge clk) begin
    if (!rstn || jump_flag_i) outstanding <= '0;
    else                      outstanding <= outstanding + CW'(grant) - CW'(fill);
  end

  // Responses still in flight that belong to a flushed stream.
  always_ff @(posedge clk) begin
    if (!rstn)            discard <= '0;
    else if (jump_flag_i) discard <= discard + DW'(outstanding) - DW'(ibus_rvalid_i);
    else if (drop)        discard <= discard - 1'b1;
  end

  // Every response must match a request or a pending discard.
  a_rvalid_expected: assert property (@(posedge clk) disable iff (!rstn)
    ibus_rvalid_i |-> (outstanding != '0 || discard != '0));
endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch with a configurable-latency instruction memory.
module tb_ifu_fetch;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [2:0]  HOLD_PC = 3'b001;
  localparam logic [2:0]  HOLD_IF = 3'b010;
  localparam logic [2:0]  HOLD_ID = 3'b011;

  logic        clk = 1'b0;
  logic        rstn;
  logic        jump;
  logic [31:0] jaddr;
  logic [2:0]  hold;
  logic        req;
  logic [31:0] addr;
  logic        gnt_en;
  logic        rvalid;
  logic [31:0] rdata;
  logic [31:0] inst;
  logic [31:0] iaddr;

  logic [2:0]        dv = '0;
  logic [2:0][31:0]  da = '0;
  logic [1:0]        lsel;   // bus latency minus one

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Memory: a granted request returns its word lsel+1 cycles later.
  always @(posedge clk) begin
    dv <= {dv[1:0], req && gnt_en};
    da <= {da[1:0], addr};
  end
  assign rvalid = dv[lsel];
  assign rdata  = memw(da[lsel]);

  ifu_fetch #(.RESET_PC(32'h0), .DEPTH(2)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .jump_flag_i   (jump),
    .jump_addr_i   (jaddr),
    .hold_flag_i   (hold),
    .ibus_req_o    (req),
    .ibus_addr_o   (addr),
    .ibus_gnt_i    (gnt_en),
    .ibus_rvalid_i (rvalid),
    .ibus_rdata_i  (rdata),
    .inst_o        (inst),
    .inst_addr_o   (iaddr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let the bus go quiet, reset the DUT, then release with a new latency.
  task automatic drain_reset(input logic [1:0] sel);
    gnt_en = 1'b0;
    repeat (4) tick();
    rstn = 1'b0;
    tick();
    lsel   = sel;
    rstn   = 1'b1;
    gnt_en = 1'b1;
    #1;
  endtask

  initial begin
    rstn = 1'b0; jump = 1'b0; jaddr = '0; hold = '0; gnt_en = 1'b1; lsel = 2'd0;
    repeat (3) tick();
    check("rst_req",   {31'h0, req}, 32'h0);
    check("rst_inst",  inst, NOP);
    check("rst_iaddr", iaddr, 32'h0);

    // Stream from reset, 1-cycle memory.
    rstn = 1'b1; #1;
    check("s0_req",  {31'h0, req}, 32'h1);
    check("s0_addr", addr, 32'h0);
    tick();
    check("s1_addr", addr, 32'h4);
    check("s1_inst", inst, NOP);
    tick();
    check("s2_iaddr", iaddr, 32'h0);
    check("s2_inst",  inst, memw(32'h0));
    check("s2_addr",  addr, 32'h8);
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("stream_iaddr", iaddr, 32'(4 * k));
      check("stream_inst",  inst, memw(32'(4 * k)));
    end

    // Hold the fetch stage for three cycles.
    hold = HOLD_IF; #1;
    check("hold_req",   {31'h0, req}, 32'h0);
    check("hold_iaddr", iaddr, 32'd20);
    repeat (2) begin
      tick();
      check("hold_iaddr", iaddr, 32'd20);
      check("hold_inst",  inst, memw(32'd20));
      check("hold_req",   {31'h0, req}, 32'h0);
    end
    tick(); hold = '0; #1;
    check("rel_iaddr", iaddr, 32'd20);
    check("rel_addr",  addr, 32'd28);
    for (int k = 6; k <= 8; k++) begin
      tick();
      check("rel_stream", iaddr, 32'(4 * k));
    end

    // Codes below Hold_If do not stall fetch; Hold_Id does.
    hold = HOLD_PC; #1;
    check("holdpc_req", {31'h0, req}, 32'h1);
    tick();
    check("holdpc_iaddr", iaddr, 32'd36);
    hold = HOLD_ID; #1;
    check("holdid_req", {31'h0, req}, 32'h0);
    tick();
    check("holdid_iaddr", iaddr, 32'd36);
    hold = '0; #1;
    tick();
    check("holdid_rel", iaddr, 32'd40);
    tick();
    check("holdid_rel", iaddr, 32'd44);

    // Grant withheld for four cycles.
    gnt_en = 1'b0; #1;
    check("nogt_addr", addr, 32'd52);
    tick();
    check("nogt_addr",  addr, 32'd52);
    check("nogt_iaddr", iaddr, 32'd48);
    repeat (2) begin
      tick();
      check("nogt_addr",  addr, 32'd52);
      check("nogt_inst",  inst, NOP);
      check("nogt_iaddr", iaddr, 32'h0);
    end
    tick(); gnt_en = 1'b1; #1;
    check("gt_addr", addr, 32'd52);
    check("gt_inst", inst, NOP);
    tick();
    check("gt_addr2", addr, 32'd56);
    tick();
    check("gt_iaddr", iaddr, 32'd52);
    check("gt_inst2", inst, memw(32'd52));

    // Jump with two fetches outstanding (3-cycle memory).
    drain_reset(2'd2);
    check("j0_addr", addr, 32'h0);
    tick();
    check("j1_addr", addr, 32'h4);
    tick();
    check("j2_full_req", {31'h0, req}, 32'h0);
    jump = 1'b1; jaddr = 32'h0000_0103; #1;
    check("j2_req", {31'h0, req}, 32'h0);
    tick(); jump = 1'b0; #1;
    check("j3_addr", addr, 32'h100);
    check("j3_inst", inst, NOP);
    tick();
    check("j4_addr", addr, 32'h104);
    check("j4_inst", inst, NOP);
    tick();
    check("j5_inst", inst, NOP);
    tick();
    check("j6_inst", inst, NOP);
    tick();
    check("j7_iaddr", iaddr, 32'h100);
    check("j7_inst",  inst, memw(32'h100));

    // Jump in the same cycle as a response, one more outstanding (2-cycle memory).
    drain_reset(2'd1);
    check("k0_addr", addr, 32'h0);
    tick();
    check("k1_addr", addr, 32'h4);
    tick();
    jump = 1'b1; jaddr = 32'h0000_0200; #1;
    check("k2_req", {31'h0, req}, 32'h0);
    tick(); jump = 1'b0; #1;
    check("k3_addr", addr, 32'h200);
    check("k3_inst", inst, NOP);
    tick();
    check("k4_addr", addr, 32'h204);
    check("k4_inst", inst, NOP);
    tick();
    check("k5_inst", inst, NOP);
    tick();
    check("k6_iaddr", iaddr, 32'h200);
    check("k6_inst",  inst, memw(32'h200));

    // PC wrap at the top of the address space, then reset mid-stream.
    drain_reset(2'd0);
    jump = 1'b1; jaddr = 32'hFFFF_FFFC; #1;
    check("w0_req", {31'h0, req}, 32'h0);
    tick(); jump = 1'b0; #1;
    check("w1_addr", addr, 32'hFFFF_FFFC);
    tick();
    check("w2_addr", addr, 32'h0);
    check("w2_inst", inst, NOP);
    tick();
    check("w3_iaddr", iaddr, 32'hFFFF_FFFC);
    check("w3_inst",  inst, memw(32'hFFFF_FFFC));
    tick();
    check("w4_iaddr", iaddr, 32'h0);
    rstn = 1'b0; #1;
    check("mrst_req",   {31'h0, req}, 32'h0);
    check("mrst_inst",  inst, NOP);
    check("mrst_iaddr", iaddr, 32'h0);
    tick();
    check("mrst_req2", {31'h0, req}, 32'h0);
    rstn = 1'b1; #1;
    check("mrel_req",  {31'h0, req}, 32'h1);
    check("mrel_addr", addr, 32'h0);
    tick();
    check("mrel_addr2", addr, 32'h4);
    tick();
    check("mrel_iaddr", iaddr, 32'h0);
    check("mrel_inst",  inst, memw(32'h0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
